button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end conditioner for the four raw player buttons, sitting directly upstream of `cpu_top` and driving its `buttons_pressed` input. It synchronizes the active-low board buttons and debounces each one independently. Each debounced press becomes one single-cycle, one-hot, active-high request. Simultaneous presses are queued and released in priority order with a guaranteed gap, so the CPU interrupt logic never sees more than one button per pulse.

## Interface
- `DEBOUNCE_CYCLES`, 500000 — consecutive stable cycles needed to accept a level change; must be ≥ 2.
- `LOCKOUT_CYCLES`, 16 — minimum idle cycles between two output pulses; must be ≥ 1.
- `clk`  input  1  — system clock; the only clock.
- `rst_n`  input  1  — reset, synchronous and active-low.
- `buttons_n`  input  4  — raw board buttons, active-low, asynchronous to `clk`.
- `buttons_pressed`  output  4  — registered one-hot request pulse, active-high; bit 3 is the highest priority.
- `buttons_level`  output  4  — debounced button level, active-high (1 = held).
- `pending`  output  4  — accepted presses not yet issued.

## Operation
- **Synchronizer:** two flops per bit, then inversion. After reset the synchronizer holds 0 (released).
- **Debounce, per bit:** counter `cnt[i]` with width ⌈log2(DEBOUNCE_CYCLES)⌉.
  - If the synced value equals `buttons_level[i]`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `buttons_level[i] <=` synced value and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Any bounce back to the old level restarts the count.
- **Press capture:** on the edge where `buttons_level[i]` goes 0→1, `pending[i] <= 1`. A 1→0 transition (release) produces nothing.
- **Issue FSM, two states:**
  - IDLE
    - If `pending != 0`, set `buttons_pressed <=` one-hot of the highest set `pending` bit and clear that `pending` bit.
    - Load the hold counter with `LOCKOUT_CYCLES` and go to HOLD.
    - Otherwise `buttons_pressed <= 0`.
  - HOLD
    - `buttons_pressed <= 0` and the hold counter decrements.
    - When the counter is 1 at an edge, it reaches 0 and the FSM goes to IDLE.
- **Set/clear collision:** if a new 0→1 capture and an issue-clear hit the same `pending` bit on the same edge, the bit stays 1 (the new press is kept).
- A button that is re-pressed while its bit is already pending merges into the existing request; there is no counting.
- **Reset:** on a reset edge, every counter, `buttons_level`, `pending`, `buttons_pressed` and the synchronizer flops go to 0 and the FSM goes to IDLE, regardless of state. A reset mid-lockout or mid-debounce discards all progress.

## Timing
- All outputs reset to 0.
- **Press latency:** take edge k as the first edge at which `buttons_n[i]` is sampled low, with the input held low and no other pending bits.
  - `buttons_level[i]` rises after edge k+1+DEBOUNCE_CYCLES.
  - `pending[i]` rises after the same edge.
  - `buttons_pressed[i]` is high for exactly the one cycle following edge k+2+DEBOUNCE_CYCLES.
- **Release latency:** `buttons_level[i]` falls DEBOUNCE_CYCLES+1 edges after the first edge that samples the input high.
- **Pulse spacing:** two pulses are at least LOCKOUT_CYCLES+1 edges apart. When a request is already waiting, the spacing is exactly LOCKOUT_CYCLES+1.
- `buttons_pressed` is never multi-hot and never high for two consecutive cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LOCKOUT_CYCLES=3, with k defined as in Timing.
- **Single press:** hold `buttons_n` = 4'b1011 for 20 cycles after reset → `buttons_pressed` = 4'b0100 for one cycle after edge k+6. `buttons_level` = 4'b0100 from edge k+5. No further pulse.
- **Bounce:** bit 0 low 3 cycles, high 1 cycle, then low 20 cycles → exactly one 4'b0001 pulse, 6 edges after the start of the final low run. Bit 0 of `buttons_level` never toggles during the bounce.
- **Simultaneous presses:** bits 3 and 0 go low on the same edge → 4'b1000 after edge k+6, then 4'b0001 after edge k+10. `pending` reads 4'b0001 in between.
- **Release:** bit 1 held for 30 cycles, then released → exactly one pulse. `buttons_level[1]` falls 5 edges after the release is first sampled, with no pulse on release.
- **Reset mid-operation:** assert `rst_n`=0 for one edge while in HOLD with `pending` = 4'b0010 → `buttons_pressed`, `pending` and `buttons_level` all read 0 next cycle. With buttons released, no pulse ever appears.
- **Collision:** bit 2 is pending and being issued while a fresh bit-2 capture lands on the same edge → `pending[2]` stays 1. A second 4'b0100 pulse follows exactly 4 edges later.

Source files
------------

// File: rtl/button_conditioner.sv
// Conditions four active-low board buttons into debounced levels and one-hot,
// single-cycle press requests issued in priority order with a lockout gap.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LOCKOUT_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] buttons_n,
  output logic [3:0] buttons_pressed,
  output logic [3:0] buttons_level,
  output logic [3:0] pending
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LOCKOUT_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [3:0]        sync1_reg, sync2_reg;
  logic [3:0]        level_bits;
  logic [3:0]        rise;
  logic [3:0]        pending_reg, pending_next;
  logic [3:0]        pressed_reg, pressed_next;
  logic [3:0]        issue;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  state_t            state_reg, state_next;

  // Inverted on entry so a cleared synchronizer already reads as released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= ~buttons_n;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_reg;
      logic             lvl_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
          lvl_reg <= 1'b0;
        end else if (sync2_reg[gi] == lvl_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          lvl_reg <= sync2_reg[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      // Capture fires on the same edge the debounced level goes high.
      assign rise[gi]       = sync2_reg[gi] & ~lvl_reg & (cnt_reg == CNT_LAST);
      assign level_bits[gi] = lvl_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      hold_reg    <= '0;
      pending_reg <= '0;
      pressed_reg <= '0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      pending_reg <= pending_next;
      pressed_reg <= pressed_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    pressed_next = '0;
    issue        = '0;
    case (state_reg)
      IDLE: begin
        if (pending_reg != '0) begin
          if (pending_reg[3])      issue = 4'b1000;
          else if (pending_reg[2]) issue = 4'b0100;
          else if (pending_reg[1]) issue = 4'b0010;
          else                     issue = 4'b0001;
          pressed_next = issue;
          hold_next    = HOLD_LOAD;
          state_next   = HOLD;
        end
      end
      HOLD: begin
        hold_next = hold_reg - HOLD_ONE;
        if (hold_reg == HOLD_ONE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A fresh capture landing on the issuing edge keeps the bit set.
    pending_next = (pending_reg & ~issue) | rise;
  end

  assign buttons_pressed = pressed_reg;
  assign buttons_level   = level_bits;
  assign pending         = pending_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed table, corner sequences
// and randomized stimulus against a sliding-window reference model.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int L  = 3;
  localparam int L2 = 12;

  logic       clk = 1'b0;
  logic       rst_n, rst_n2;
  logic [3:0] buttons_n, buttons_n2;
  logic [3:0] buttons_pressed, buttons_level, pending;
  logic [3:0] pressed2, level2, pending2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) u_dut (
    .clk(clk), .rst_n(rst_n), .buttons_n(buttons_n),
    .buttons_pressed(buttons_pressed), .buttons_level(buttons_level), .pending(pending)
  );

  // Longer lockout lets a re-debounced press land on the edge that issues it.
  button_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L2)) u_dut_long (
    .clk(clk), .rst_n(rst_n2), .buttons_n(buttons_n2),
    .buttons_pressed(pressed2), .buttons_level(level2), .pending(pending2)
  );

  // Reference model: a level flips once the last D synchronized samples all
  // disagree with it; issues are spaced by at least L+1 edges.
  logic [3:0] hist [0:D];
  logic [3:0] m_level, m_pending, m_pressed;
  int         edge_no = 0;
  int         last_issue = -1000;
  logic [3:0] prev_pressed = '0;
  logic [3:0] prev_level = '0;
  int         pulse_edges[$];
  logic [3:0] pulse_vals[$];
  int         level_edges[$];
  logic [3:0] level_vals[$];
  int         col_edges[$];
  logic [3:0] col_vals[$];

  typedef struct {
    logic [3:0] bn;
    logic       rn;
    int         reps;
    logic [3:0] e_pressed;
    logic [3:0] e_level;
    logic [3:0] e_pending;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%b required=%b", name, edge_no, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_no, act, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] bn, input logic rn);
    logic [3:0] rises;
    logic [3:0] pick;
    bit         flip;
    rises = '0;
    pick  = '0;
    if (!rn) begin
      for (int j = 0; j <= D; j++) hist[j] = '0;
      m_level    = '0;
      m_pending  = '0;
      m_pressed  = '0;
      last_issue = -1000;
    end else begin
      for (int b = 0; b < 4; b++) begin
        flip = 1'b1;
        for (int j = 1; j <= D; j++) if (hist[j][b] == m_level[b]) flip = 1'b0;
        if (flip) begin
          m_level[b] = ~m_level[b];
          if (m_level[b]) rises[b] = 1'b1;
        end
      end
      if (m_pending != '0 && (edge_no - last_issue) >= L + 1) begin
        for (int b = 0; b < 4; b++) if (m_pending[b]) pick = 4'b0001 << b;
        last_issue = edge_no;
      end
      m_pressed = pick;
      m_pending = (m_pending & ~pick) | rises;
      for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = ~bn;
    end
  endtask

  task automatic step(input logic [3:0] bn, input logic rn);
    buttons_n = bn;
    rst_n     = rn;
    @(posedge clk);
    edge_no++;
    model_edge(bn, rn);
    #1;
    check_int("onehot", int'($onehot0(buttons_pressed)), 1);
    check_int("back_to_back", int'(prev_pressed != '0 && buttons_pressed != '0), 0);
    if (buttons_pressed != '0) begin
      pulse_edges.push_back(edge_no);
      pulse_vals.push_back(buttons_pressed);
    end
    if (buttons_level != prev_level) begin
      level_edges.push_back(edge_no);
      level_vals.push_back(buttons_level);
    end
    prev_pressed = buttons_pressed;
    prev_level   = buttons_level;
  endtask

  task automatic reset_and_clear();
    step(4'hF, 1'b0);
    pulse_edges.delete();
    pulse_vals.delete();
    level_edges.delete();
    level_vals.delete();
  endtask

  initial begin
    int         s;
    int         r;
    logic [3:0] bn2;
    logic [3:0] cur;
    int         run_left [4];
    logic       rn;

    buttons_n  = 4'hF;
    rst_n      = 1'b0;
    buttons_n2 = 4'hF;
    rst_n2     = 1'b0;

    // Single press then release, one record per run of identical cycles.
    vecs[0] = '{4'hF, 1'b0, 1,  4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{4'hB, 1'b1, 5,  4'b0000, 4'b0000, 4'b0000};
    vecs[2] = '{4'hB, 1'b1, 1,  4'b0000, 4'b0100, 4'b0100};
    vecs[3] = '{4'hB, 1'b1, 1,  4'b0100, 4'b0100, 4'b0000};
    vecs[4] = '{4'hB, 1'b1, 13, 4'b0000, 4'b0100, 4'b0000};
    vecs[5] = '{4'hF, 1'b1, 5,  4'b0000, 4'b0100, 4'b0000};
    vecs[6] = '{4'hF, 1'b1, 6,  4'b0000, 4'b0000, 4'b0000};
    for (int v = 0; v < 7; v++) begin
      for (int n = 0; n < vecs[v].reps; n++) begin
        step(vecs[v].bn, vecs[v].rn);
        check("tbl_pressed", buttons_pressed, vecs[v].e_pressed);
        check("tbl_level", buttons_level, vecs[v].e_level);
        check("tbl_pending", pending, vecs[v].e_pending);
      end
    end

    // Bounce on bit 0: a 3-cycle low run must not be accepted.
    reset_and_clear();
    for (int n = 0; n < 3; n++) step(4'b1110, 1'b1);
    step(4'b1111, 1'b1);
    s = edge_no + 1;
    for (int n = 0; n < 20; n++) step(4'b1110, 1'b1);
    check_int("bounce_pulse_count", pulse_edges.size(), 1);
    check_int("bounce_pulse_edge", (pulse_edges.size() > 0) ? pulse_edges[0] : -1, s + 6);
    check("bounce_pulse_val", (pulse_vals.size() > 0) ? pulse_vals[0] : 4'b0000, 4'b0001);
    check_int("bounce_level_changes", level_edges.size(), 1);
    check_int("bounce_level_edge", (level_edges.size() > 0) ? level_edges[0] : -1, s + 5);

    // Simultaneous bits 3 and 0.
    reset_and_clear();
    s = edge_no + 1;
    for (int n = 0; n < 25; n++) begin
      step(4'b0110, 1'b1);
      if (edge_no >= s + 7 && edge_no <= s + 9) check("simul_pending", pending, 4'b0001);
    end
    check_int("simul_pulse_count", pulse_edges.size(), 2);
    check_int("simul_edge0", (pulse_edges.size() > 0) ? pulse_edges[0] : -1, s + 6);
    check("simul_val0", (pulse_vals.size() > 0) ? pulse_vals[0] : 4'b0000, 4'b1000);
    check_int("simul_edge1", (pulse_edges.size() > 1) ? pulse_edges[1] : -1, s + 10);
    check("simul_val1", (pulse_vals.size() > 1) ? pulse_vals[1] : 4'b0000, 4'b0001);

    // Hold bit 1 then release: no pulse on release, level falls D+1 edges later.
    reset_and_clear();
    for (int n = 0; n < 30; n++) step(4'b1101, 1'b1);
    r = edge_no + 1;
    for (int n = 0; n < 15; n++) step(4'b1111, 1'b1);
    check_int("release_pulse_count", pulse_edges.size(), 1);
    check("release_pulse_val", (pulse_vals.size() > 0) ? pulse_vals[0] : 4'b0000, 4'b0010);
    check_int("release_level_changes", level_edges.size(), 2);
    check_int("release_fall_edge", (level_edges.size() > 1) ? level_edges[1] : -1, r + 5);

    // Reset during HOLD with bit 1 still pending.
    reset_and_clear();
    for (int n = 0; n < 8; n++) step(4'b1001, 1'b1);
    check("midrst_pending_before", pending, 4'b0010);
    check("midrst_pressed_before", buttons_pressed, 4'b0000);
    step(4'b1111, 1'b0);
    check("midrst_pressed", buttons_pressed, 4'b0000);
    check("midrst_pending", pending, 4'b0000);
    check("midrst_level", buttons_level, 4'b0000);
    pulse_edges.delete();
    pulse_vals.delete();
    for (int n = 0; n < 20; n++) step(4'b1111, 1'b1);
    check_int("midrst_no_pulse", pulse_edges.size(), 0);

    // Collision on the long-lockout instance: bit 2 re-captured on its issue edge.
    @(negedge clk);
    rst_n2     = 1'b0;
    buttons_n2 = 4'hF;
    @(posedge clk);
    #1;
    check("col_reset", pressed2 | level2 | pending2, 4'b0000);
    for (int j = 0; j < 40; j++) begin
      bn2 = 4'b1101;
      if ((j >= 2 && j <= 5) || j >= 14) bn2[2] = 1'b0;
      buttons_n2 = bn2;
      rst_n2     = 1'b1;
      @(posedge clk);
      #1;
      if (pressed2 != '0) begin
        col_edges.push_back(j);
        col_vals.push_back(pressed2);
      end
      if (j == 19) check("col_pending_kept", pending2, 4'b0100);
    end
    check_int("col_pulse_count", col_edges.size(), 3);
    check_int("col_edge0", (col_edges.size() > 0) ? col_edges[0] : -1, 6);
    check("col_val0", (col_vals.size() > 0) ? col_vals[0] : 4'b0000, 4'b0010);
    check_int("col_edge1", (col_edges.size() > 1) ? col_edges[1] : -1, 19);
    check("col_val1", (col_vals.size() > 1) ? col_vals[1] : 4'b0000, 4'b0100);
    check_int("col_edge2", (col_edges.size() > 2) ? col_edges[2] : -1, 19 + L2 + 1);
    check("col_val2", (col_vals.size() > 2) ? col_vals[2] : 4'b0000, 4'b0100);

    // Random runs per button with occasional resets, compared to the model.
    reset_and_clear();
    cur = 4'hF;
    for (int b = 0; b < 4; b++) run_left[b] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (run_left[b] == 0) begin
          cur[b]      = 1'($urandom_range(0, 1));
          run_left[b] = int'($urandom_range(1, 12));
        end
        run_left[b]--;
      end
      rn = ($urandom_range(0, 299) != 0);
      step(cur, rn);
      check("rnd_pressed", buttons_pressed, m_pressed);
      check("rnd_level", buttons_level, m_level);
      check("rnd_pending", pending, m_pending);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
